// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared defaults and constants for the multiplexed 7-segment scanner
package display_pkg;

    localparam int DEF_SEG_W        = 7;
    localparam int DEF_CLK_DIV      = 1350;
    localparam int DEF_BLANK_CYC    = 16;
    localparam int DEF_BLINK_FRAMES = 64;

    // Logical (polarity-free) pattern with every segment off.
    localparam logic [DEF_SEG_W-1:0] BLANK_PATTERN = '0;

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - slot counter and digit index for the display scanner
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   run         1 = count; 0 = hold cnt and idx cleared
//   cnt         cycle position inside the current digit slot (0..CLK_DIV-1)
//   idx         digit currently being scanned (0..NUM_DIGITS-1)
//   slot_end    cnt is on the last cycle of its slot
//   frame_wrap  last cycle of the last digit slot (idx wraps to 0 next)
module scan_timer #(
    parameter  int NUM_DIGITS = 8,
    parameter  int CLK_DIV    = 1350,
    localparam int CW         = $clog2(CLK_DIV),
    localparam int IW         = $clog2(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [CW-1:0] cnt,
    output logic [IW-1:0] idx,
    output logic          slot_end,
    output logic          frame_wrap
);

    assign slot_end   = (cnt == CW'(CLK_DIV - 1));
    assign frame_wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!run) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= frame_wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - multiplexed 7-segment display scanner with PWM brightness and blink
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   enable       1 = scan runs, 0 = display dark and scan state cleared
//   digits_in    packed segment patterns, digit 0 in the top SEG_W bits, 1 = lit
//   blink_mask   bit i = 1 makes digit i blink
//   brightness   0 = off .. 15 = full on-time within each slot
//   seg_out      registered segment drive (polarity from SEG_ACT_LOW)
//   sel_out      registered one-hot-or-zero digit select (polarity from SEL_ACT_LOW)
//   frame_tick   one-cycle pulse as each frame starts
//   led_on       registered copy of enable
module display_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SEG_W        = DEF_SEG_W,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int BLANK_CYC    = DEF_BLANK_CYC,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit SEL_ACT_LOW  = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic [3:0]                  brightness,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       sel_out,
    output logic                        frame_tick,
    output logic                        led_on
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [31:0] STEP_U  = 32'((CLK_DIV - BLANK_CYC) / 15);
    localparam logic [31:0] BLANK_U = 32'(BLANK_CYC);

    // XOR masks that turn logical (1 = on) values into pin polarity.
    localparam logic [SEG_W-1:0]      SEG_POL   = {SEG_W{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] SEL_POL   = {NUM_DIGITS{SEL_ACT_LOW}};
    localparam logic [SEG_W-1:0]      SEG_BLANK = SEG_W'(BLANK_PATTERN);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          slot_end;
    logic          frame_wrap;

    logic                        run;
    logic                        start;
    logic                        frame_end;
    logic                        load;
    logic [NUM_DIGITS*SEG_W-1:0] digits_sh;
    logic [NUM_DIGITS-1:0]       mask_sh;
    logic [FW-1:0]               frame_cnt;
    logic                        blink_phase;

    logic [SEG_W-1:0]      pat_arr [NUM_DIGITS];
    logic [SEG_W-1:0]      pat;
    logic [NUM_DIGITS-1:0] onehot;
    logic [31:0]           cnt_u;
    logic [31:0]           on_end;
    logic                  lit;

    // led_on doubles as the registered enable: the first enabled cycle
    // (led_on still 0) reloads the shadows and holds cnt at 0, so the
    // following cycle is cnt=0 of digit 0 with fresh patterns.
    assign run       = enable && led_on;
    assign start     = enable && !led_on;
    assign frame_end = run && slot_end && frame_wrap;
    assign load      = start || frame_end;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .CLK_DIV    (CLK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cnt        (cnt),
        .idx        (idx),
        .slot_end   (slot_end),
        .frame_wrap (frame_wrap)
    );

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_unpack
        assign pat_arr[i] = digits_sh[(NUM_DIGITS-i)*SEG_W-1 -: SEG_W];
    end

    always_comb begin
        pat    = pat_arr[idx];
        onehot = NUM_DIGITS'(1) << idx;
        cnt_u  = 32'(cnt);
        on_end = BLANK_U + STEP_U * {28'd0, brightness};
        // Full brightness runs to the end of the slot even when STEP*15
        // falls short of CLK_DIV-BLANK_CYC due to integer division.
        lit    = run
              && (cnt_u >= BLANK_U)
              && ((brightness == 4'd15) || (cnt_u < on_end))
              && !(blink_phase && mask_sh[idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_sh   <= '0;
            mask_sh     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_tick  <= 1'b0;
            led_on      <= 1'b0;
            seg_out     <= SEG_BLANK ^ SEG_POL;
            sel_out     <= SEL_POL;
        end else begin
            led_on     <= enable;
            frame_tick <= load;
            if (load) begin
                digits_sh <= digits_in;
                mask_sh   <= blink_mask;
            end
            if (!enable) begin
                frame_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (frame_end) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            seg_out <= (lit ? pat : SEG_BLANK) ^ SEG_POL;
            sel_out <= (lit ? onehot : '0) ^ SEL_POL;
        end
    end

endmodule
